// File: rtl/regfile_param_if.sv
// Register-file access bundle: one write port, two read ports, error flag.
// The master side drives selects and write data; the slave is the register file.
interface regfile_param_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned REGS  = 8
);
  localparam int unsigned SEL_W = $clog2(REGS);

  logic             write;
  logic [SEL_W-1:0] writeregsel;
  logic [WIDTH-1:0] writedata;
  logic [SEL_W-1:0] read1regsel;
  logic [SEL_W-1:0] read2regsel;
  logic [WIDTH-1:0] read1data;
  logic [WIDTH-1:0] read2data;
  logic             err;

  modport master (
    output write, writeregsel, writedata, read1regsel, read2regsel,
    input  read1data, read2data, err
  );

  modport slave (
    input  write, writeregsel, writedata, read1regsel, read2regsel,
    output read1data, read2data, err
  );
endinterface

// File: rtl/regfile_param.sv
// Parametrised register file: REGS x WIDTH flops, one synchronous write port,
// two combinational read ports, out-of-range access flag.
// Optional write-to-read bypass: define REGFILE_BYPASS_EN.
// WIDTH/REGS must match the parameters of the connected regfile_param_if.
module regfile_param #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned REGS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_param_if.slave       bus
);
  localparam int unsigned        SEL_W = $clog2(REGS);
  localparam logic [SEL_W:0]     LIMIT = (SEL_W+1)'(REGS);

  logic [WIDTH-1:0] regs     [REGS];
  logic [WIDTH-1:0] regs_nxt [REGS];
  logic             wr_oor;
  logic             r1_oor;
  logic             r2_oor;
  logic             wr_en;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  logic             err_c;

  // Range decode of the three selects; a select beyond REGS-1 is illegal.
  always_comb begin
    wr_oor = ({1'b0, bus.writeregsel} >= LIMIT);
    r1_oor = ({1'b0, bus.read1regsel} >= LIMIT);
    r2_oor = ({1'b0, bus.read2regsel} >= LIMIT);
    wr_en  = bus.write & ~wr_oor;
  end

  // Per-register 2:1 select: load write data when addressed, else recirculate.
  always_comb begin
    for (int unsigned i = 0; i < REGS; i++) begin
      regs_nxt[i] = (wr_en && (bus.writeregsel == SEL_W'(i))) ? bus.writedata : regs[i];
    end
  end

  // Storage flops with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < REGS; i++) regs[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < REGS; i++) regs[i] <= regs_nxt[i];
    end
  end

  // Read muxes; an unmatched (out-of-range) select leaves the port at zero.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    for (int unsigned i = 0; i < REGS; i++) begin
      if (bus.read1regsel == SEL_W'(i)) rd1 = regs[i];
      if (bus.read2regsel == SEL_W'(i)) rd2 = regs[i];
    end
`ifdef REGFILE_BYPASS_EN
    // Same-cycle forwarding of the pending write, gated off while in reset.
    if (rst && wr_en && (bus.read1regsel == bus.writeregsel)) rd1 = bus.writedata;
    if (rst && wr_en && (bus.read2regsel == bus.writeregsel)) rd2 = bus.writedata;
`endif
  end

  // Illegal-access flag; an unknown write enable outside reset is also flagged.
  always_comb begin
    err_c = (bus.write & wr_oor) | r1_oor | r2_oor;
`ifndef SYNTHESIS
    if (rst && $isunknown(bus.write)) err_c = 1'b1;
`endif
  end

  assign bus.read1data = rd1;
  assign bus.read2data = rd2;
  assign bus.err       = err_c;
endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: an 8x16 instance and a 6x16 instance (out-of-range
// selects), random stimulus against an array model, queued expectations
// checked by an independent monitor process.
module tb_regfile_param;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  regfile_param_if #(.WIDTH(16), .REGS(8)) ifa ();
  regfile_param_if #(.WIDTH(16), .REGS(6)) ifb ();

  regfile_param #(.WIDTH(16), .REGS(8)) ua (.clk(clk), .rst(rst), .bus(ifa));
  regfile_param #(.WIDTH(16), .REGS(6)) ub (.clk(clk), .rst(rst), .bus(ifb));

  typedef struct {
    int          w;
    string       name;
    logic [15:0] r1;
    logic [15:0] r2;
    logic        e;
  } exp_t;

  exp_t q[$];
  event chk_ev;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] ma [8];
  logic [15:0] mb [6];

  function automatic int nregs(int w);
    return (w == 0) ? 8 : 6;
  endfunction

  function automatic logic [15:0] mread(int w, int sel, logic wr, int ws, logic [15:0] wd, logic rs);
    if (!rs) return 16'h0000;
    if (sel >= nregs(w)) return 16'h0000;
`ifdef REGFILE_BYPASS_EN
    if (wr && ws < nregs(w) && ws == sel) return wd;
`endif
    return (w == 0) ? ma[sel] : mb[sel];
  endfunction

  task automatic clear_models();
    for (int i = 0; i < 8; i++) ma[i] = 16'h0000;
    for (int i = 0; i < 6; i++) mb[i] = 16'h0000;
  endtask

  // Queue what the spec says the outputs must be for the currently driven inputs.
  task automatic expect_now(int w, string name);
    exp_t x;
    logic wr; int ws, s1, s2; logic [15:0] wd;
    if (w == 0) begin
      wr = ifa.write; ws = int'(ifa.writeregsel); wd = ifa.writedata;
      s1 = int'(ifa.read1regsel); s2 = int'(ifa.read2regsel);
    end else begin
      wr = ifb.write; ws = int'(ifb.writeregsel); wd = ifb.writedata;
      s1 = int'(ifb.read1regsel); s2 = int'(ifb.read2regsel);
    end
    x.w    = w;
    x.name = name;
    x.r1   = mread(w, s1, wr, ws, wd, rst);
    x.r2   = mread(w, s2, wr, ws, wd, rst);
    x.e    = (wr && ws >= nregs(w)) || s1 >= nregs(w) || s2 >= nregs(w);
    q.push_back(x);
    -> chk_ev;
    for (int k = 0; k < 3; k++) begin
      if (q.size() == 0) break;
      #1;
    end
    if (q.size() != 0) begin
      $display("FAIL monitor_timeout %s pending=%0d required=0", name, q.size());
      errors++;
      q.delete();
    end
  endtask

  // Monitor: whenever outputs are presented for checking, pop and compare.
  initial begin
    exp_t x;
    logic [15:0] a1, a2;
    logic ae;
    forever begin
      @(chk_ev);
      while (q.size() > 0) begin
        x = q.pop_front();
        if (x.w == 0) begin a1 = ifa.read1data; a2 = ifa.read2data; ae = ifa.err; end
        else          begin a1 = ifb.read1data; a2 = ifb.read2data; ae = ifb.err; end
        checks++;
        if (a1 !== x.r1 || a2 !== x.r2 || ae !== x.e) begin
          errors++;
          $display("FAIL %s dut=%0d rd1 got %h want %h rd2 got %h want %h err got %b want %b",
                   x.name, x.w, a1, x.r1, a2, x.r2, ae, x.e);
        end
      end
    end
  end

  // One clock: model applies the write the DUT sees at the rising edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      if (ifa.write && int'(ifa.writeregsel) < 8) ma[ifa.writeregsel] = ifa.writedata;
      if (ifb.write && int'(ifb.writeregsel) < 6) mb[ifb.writeregsel] = ifb.writedata;
    end
    @(negedge clk);
  endtask

  task automatic drv_a(logic wr, int ws, logic [15:0] wd, int s1, int s2);
    ifa.write = wr; ifa.writeregsel = 3'(ws); ifa.writedata = wd;
    ifa.read1regsel = 3'(s1); ifa.read2regsel = 3'(s2);
  endtask

  task automatic drv_b(logic wr, int ws, logic [15:0] wd, int s1, int s2);
    ifb.write = wr; ifb.writeregsel = 3'(ws); ifb.writedata = wd;
    ifb.read1regsel = 3'(s1); ifb.read2regsel = 3'(s2);
  endtask

  initial begin
    rst = 1'b0;
    clear_models();
    drv_a(1'b0, 0, 16'h0, 0, 0);
    drv_b(1'b0, 0, 16'h0, 0, 0);

    // Reset: outputs zero with no clock edge, err follows selects
    drv_a(1'b1, 3'($urandom), 16'($urandom), 3'($urandom), 3'($urandom));
    drv_b(1'b0, 0, 16'h0, 3'($urandom), 3'($urandom));
    #1 expect_now(0, "reset_a");
    expect_now(1, "reset_b");

    @(negedge clk);
    rst = 1'b1;
    drv_a(1'b0, 0, 16'($urandom), 0, 7);
    drv_b(1'b0, 0, 16'h0, 0, 5);
    tick();
    for (int i = 0; i < 8; i++) begin
      drv_a(1'b0, 0, 16'h0, i, 7 - i);
      #1 expect_now(0, "rst_zero");
      @(negedge clk);
    end

    // Write/read all
    for (int i = 0; i < 8; i++) begin
      drv_a(1'b1, i, 16'(16'h1111 * i), 0, 0);
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      drv_a(1'b0, 0, 16'h0, i, 7 - i);
      #1 expect_now(0, "rw_all");
      @(negedge clk);
    end

    // Same-cycle hazard on register 3
    drv_a(1'b1, 3, 16'hAAAA, 0, 1);
    tick();
    drv_a(1'b1, 3, 16'h5555, 3, 3);
    #1 expect_now(0, "hazard_before");
    tick();
    drv_a(1'b0, 0, 16'h0, 3, 2);
    #1 expect_now(0, "hazard_after");

    // Async reset in the middle of a pending write
    @(negedge clk);
    drv_a(1'b1, 5, 16'h1234, 0, 0);
    tick();
    drv_a(1'b1, 5, 16'hFFFF, 5, 4);
    #1 expect_now(0, "pre_rst_mid");
    #1 rst = 1'b0;
    clear_models();
    #1 expect_now(0, "rst_mid");
    tick();
    expect_now(0, "rst_edge");
    rst = 1'b1;
    drv_a(1'b0, 0, 16'h0, 5, 3);
    #1 expect_now(0, "after_rst");
    @(negedge clk);

    // Out-of-range on the 6-register instance
    for (int i = 0; i < 6; i++) begin
      drv_b(1'b1, i, 16'($urandom), 0, 0);
      tick();
    end
    drv_b(1'b1, 7, 16'hBEEF, 0, 1);
    #1 expect_now(1, "oor_write7");
    tick();
    drv_b(1'b1, 6, 16'hBEEF, 2, 3);
    #1 expect_now(1, "oor_write6");
    tick();
    for (int i = 0; i < 6; i++) begin
      drv_b(1'b0, 0, 16'h0, i, 5 - i);
      #1 expect_now(1, "oor_hold");
      @(negedge clk);
    end
    drv_b(1'b0, 0, 16'h0, 6, 2);
    #1 expect_now(1, "oor_read6");
    drv_b(1'b0, 0, 16'h0, 4, 7);
    #1 expect_now(1, "oor_read7");
    @(negedge clk);

    // Hold: register 2 keeps its value through write=0 cycles
    drv_a(1'b1, 2, 16'hC3C3, 0, 0);
    tick();
    for (int i = 0; i < 20; i++) begin
      drv_a(1'b0, 3'($urandom), 16'($urandom), 2, 3'($urandom));
      #1 expect_now(0, "hold");
      tick();
    end

    // Random traffic on both instances
    for (int i = 0; i < 300; i++) begin
      drv_a(1'($urandom), 3'($urandom), 16'($urandom), 3'($urandom), 3'($urandom));
      drv_b(1'($urandom), 3'($urandom), 16'($urandom), 3'($urandom), 3'($urandom));
      #1 expect_now(0, "rand_a");
      expect_now(1, "rand_b");
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised multi-register storage block: an array of `REGS` registers, each `WIDTH` bits wide, with one synchronous write port and two asynchronous read ports. It is the general form of the team's single 16-bit write-enabled register. It serves as the processor's general-purpose register file and as a scratch bank for multi-word datapath blocks. Optional write-to-read bypass is selected at compile time.

## Interface
Parameters:
- `WIDTH`, 16, bits per register (≥1)
- `REGS`, 8, number of registers (≥2; need not be a power of two)
- `SEL_W`, derived = ceil(log2(REGS)), register-select width; not overridden by instantiators

Ports:
- `clk`  input  1  single clock; all state updates on rising edge
- `rst`  input  1  asynchronous, active-low reset; low forces all registers to 0 immediately, independent of `clk`
- `write`  input  1  write enable
- `writeregsel`  input  SEL_W  destination register index
- `writedata`  input  WIDTH  data to store
- `read1regsel`  input  SEL_W  read port 1 index
- `read2regsel`  input  SEL_W  read port 2 index
- `read1data`  output  WIDTH  contents of register `read1regsel`
- `read2data`  output  WIDTH  contents of register `read2regsel`
- `err`  output  1  illegal access flag

## Operation
- Storage: `REGS` × `WIDTH` flops. Each flop holds its value unless written. Holding is done by recirculating through a 2:1 select, not by clock gating.
- Write: on a rising `clk` with `write`=1, `rst`=1 and `writeregsel` < `REGS`, register[`writeregsel`] ← `writedata`. All other registers hold.
- Out-of-range write (`writeregsel` ≥ `REGS`): no register changes.
- Read: both read ports are purely combinational muxes of current register state. Reads never alter state. Both ports may select the same register.
- Out-of-range read select: the port drives all-zeros.
- `err` (combinational) = (`write` & `writeregsel` ≥ `REGS`) | (`read1regsel` ≥ `REGS`) | (`read2regsel` ≥ `REGS`). `err` never blocks an in-range access on another port.
- X on `write` while `rst`=1: `err` is asserted in simulation. Contents after such an edge are undefined.

## Timing
- Reset: while `rst`=0, all registers are 0, so `read1data` = `read2data` = 0. `err` still reflects the select inputs.
- Deassertion of `rst`: the first write takes effect on the first rising edge with `rst`=1.
- Write latency: 1 cycle. Data written at edge N is visible on the read ports after edge N. With bypass, it is also visible during the cycle before edge N.
- Read latency: 0 cycles (combinational from the select inputs and register state).
- Simultaneous read and write of the same register without bypass: the read returns the old value until the edge.
- Reset mid-operation: asserting `rst` low between edges clears all registers immediately. A write pending at the next edge is discarded while `rst`=0.

## Configuration
- Macro `REGFILE_BYPASS_EN`.
- Defined: when `write`=1, `writeregsel` < `REGS` and `readNregsel` == `writeregsel`, `readNdata` = `writedata` combinationally, for each port independently. Bypass is suppressed while `rst`=0, so outputs remain 0 during reset.
- Undefined: the read ports show stored state only, with no write-to-read path.

## Test plan
- Reset: drive `rst`=0 with random selects. Expect `read1data`=`read2data`=0x0000 at once, without a clock edge. Release, clock once with `write`=0, and all registers still read 0.
- Write/read all (WIDTH=16, REGS=8): write 0x1111·i to register i for i=0..7 over 8 cycles. Read pairs (i, 7−i) and expect the matching values on both ports. `err`=0 throughout.
- Same-cycle hazard: register 3 = 0xAAAA. Drive `write`=1, `writeregsel`=3, `writedata`=0x5555, `read1regsel`=3.
  - Without macro: 0xAAAA before the edge, 0x5555 after.
  - With macro: 0x5555 before the edge.
- Async reset mid-write: register 5 = 0x1234. Drive `rst`=0 mid-cycle with `write`=1 to register 5 at 0xFFFF. Outputs read 0 immediately. The edge while in reset leaves register 5 = 0.
- Out-of-range (REGS=6, SEL_W=3): write 0xBEEF to index 7. Expect `err`=1 and no register changed. Read index 6: `err`=1 and data 0x0000. An in-range read on the other port returns correct data.
- Hold: write 0xC3C3 to register 2, then run 20 cycles of `write`=0 with random `writedata`. Register 2 stays 0xC3C3.
